// File: rtl/bp_nonsynth_commit_watchdog.sv
// Run-control monitor on the commit path: counts retirements, detects hangs,
// self-loops and the instruction cap, then drains before raising finish.
module bp_nonsynth_commit_watchdog #(
    parameter int vaddr_width_p    = 39,
    parameter int stall_timeout_p  = 16384,
    parameter int loop_threshold_p = 8,
    parameter int drain_cycles_p   = 64
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     freeze_i,
    input  logic                     en_i,
    input  logic                     commit_v_i,
    input  logic                     trap_v_i,
    input  logic [vaddr_width_p-1:0] commit_pc_i,
    input  logic [31:0]              commit_instr_i,
    input  logic [31:0]              instr_cap_i,
    input  logic                     drained_i,
    output logic [31:0]              instr_cnt_o,
    output logic [1:0]               state_o,
    output logic                     finish_o,
    output logic                     hang_o,
    output logic                     loop_o,
    output logic                     cap_o
);

    localparam int stall_width_lp = (stall_timeout_p > 2) ? $clog2(stall_timeout_p) : 1;
    localparam int loop_width_lp  = $clog2(loop_threshold_p + 1);
    localparam int drain_width_lp = (drain_cycles_p > 1) ? $clog2(drain_cycles_p) : 1;

    localparam logic [31:0]               self_jump_lp  = 32'h0000_006f;
    localparam logic [stall_width_lp-1:0] stall_last_lp = stall_width_lp'(stall_timeout_p - 1);
    localparam logic [loop_width_lp-1:0]  loop_hit_lp   = loop_width_lp'(loop_threshold_p);
    localparam logic [drain_width_lp-1:0] drain_last_lp = drain_width_lp'(drain_cycles_p - 1);

    typedef enum logic [1:0] {
        e_idle  = 2'd0,
        e_run   = 2'd1,
        e_drain = 2'd2,
        e_done  = 2'd3
    } state_e;

    state_e                     state_q,     state_d;
    logic [31:0]                instr_cnt_q, instr_cnt_d;
    logic [stall_width_lp-1:0]  stall_cnt_q, stall_cnt_d;
    logic [loop_width_lp-1:0]   loop_cnt_q,  loop_cnt_d;
    logic [drain_width_lp-1:0]  drain_cnt_q, drain_cnt_d;
    logic [vaddr_width_p-1:0]   last_pc_q,   last_pc_d;
    logic                       finish_q, finish_d;
    logic                       hang_q,   hang_d;
    logic                       loop_q,   loop_d;
    logic                       cap_q,    cap_d;

    logic [31:0]                instr_cnt_inc;
    logic                       self_jump;

    assign instr_cnt_inc = (instr_cnt_q == '1) ? instr_cnt_q : instr_cnt_q + 32'd1;
    assign self_jump     = (commit_instr_i == self_jump_lp);

    // NOTE: every next-state variable is defaulted to its held value first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        instr_cnt_d = instr_cnt_q;
        stall_cnt_d = stall_cnt_q;
        loop_cnt_d  = loop_cnt_q;
        drain_cnt_d = drain_cnt_q;
        last_pc_d   = last_pc_q;
        finish_d    = finish_q;
        hang_d      = hang_q;
        loop_d      = loop_q;
        cap_d       = cap_q;

        unique case (state_q)
            e_idle: begin
                if (en_i && !freeze_i) state_d = e_run;
            end

            e_run: begin
                if (!en_i) begin
                    state_d = e_idle;
                end else begin
                    if (commit_v_i) begin
                        instr_cnt_d = instr_cnt_inc;
                        last_pc_d   = commit_pc_i;
                        if (self_jump && (commit_pc_i == last_pc_q))
                            loop_cnt_d = loop_cnt_q + loop_width_lp'(1);
                        else if (self_jump)
                            loop_cnt_d = loop_width_lp'(1);
                        else
                            loop_cnt_d = '0;
                    end

                    // Any commit clears the stall counter, so hang and cap/loop are exclusive.
                    if (commit_v_i || trap_v_i) begin
                        stall_cnt_d = '0;
                    end else if (!freeze_i) begin
                        if (stall_cnt_q == stall_last_lp) begin
                            hang_d   = 1'b1;
                            finish_d = 1'b1;
                            state_d  = e_done;
                        end else begin
                            stall_cnt_d = stall_cnt_q + stall_width_lp'(1);
                        end
                    end

                    if (commit_v_i) begin
                        if (loop_cnt_d == loop_hit_lp) begin
                            loop_d  = 1'b1;
                            state_d = e_drain;
                        end
                        if ((instr_cap_i != 32'd0) && (instr_cnt_d == instr_cap_i)) begin
                            cap_d   = 1'b1;
                            state_d = e_drain;
                        end
                    end
                end
            end

            e_drain: begin
                drain_cnt_d = drain_cnt_q + drain_width_lp'(1);
                if (commit_v_i) instr_cnt_d = instr_cnt_inc;
                if (drained_i || (drain_cnt_q == drain_last_lp)) begin
                    finish_d = 1'b1;
                    state_d  = e_done;
                end
            end

            e_done: begin
            end

            default: state_d = e_idle;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= e_idle;
            instr_cnt_q <= '0;
            stall_cnt_q <= '0;
            loop_cnt_q  <= '0;
            drain_cnt_q <= '0;
            last_pc_q   <= '0;
            finish_q    <= 1'b0;
            hang_q      <= 1'b0;
            loop_q      <= 1'b0;
            cap_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_cnt_q <= instr_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            loop_cnt_q  <= loop_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            last_pc_q   <= last_pc_d;
            finish_q    <= finish_d;
            hang_q      <= hang_d;
            loop_q      <= loop_d;
            cap_q       <= cap_d;
        end
    end

    assign instr_cnt_o = instr_cnt_q;
    assign state_o     = state_q;
    assign finish_o    = finish_q;
    assign hang_o      = hang_q;
    assign loop_o      = loop_q;
    assign cap_o       = cap_q;

endmodule

// File: tb/tb_bp_nonsynth_commit_watchdog.sv
// Directed bench for bp_nonsynth_commit_watchdog: a cap/enable vector table
// followed by hand-written loop, hang, freeze/trap, reset and saturation sequences.
module tb_bp_nonsynth_commit_watchdog;

    localparam int va_lp = 39;
    localparam logic [1:0] s_idle = 2'd0, s_run = 2'd1, s_drain = 2'd2, s_done = 2'd3;
    localparam logic [31:0] jal_self = 32'h0000_006f;
    localparam logic [31:0] nop      = 32'h0000_0013;

    logic             clk_i = 1'b0;
    logic             reset_i, freeze_i, en_i, commit_v_i, trap_v_i, drained_i;
    logic [va_lp-1:0] commit_pc_i;
    logic [31:0]      commit_instr_i, instr_cap_i;
    logic [31:0]      instr_cnt_o;
    logic [1:0]       state_o;
    logic             finish_o, hang_o, loop_o, cap_o;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    bp_nonsynth_commit_watchdog #(
        .vaddr_width_p   (va_lp),
        .stall_timeout_p (16),
        .loop_threshold_p(8),
        .drain_cycles_p  (64)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .freeze_i      (freeze_i),
        .en_i          (en_i),
        .commit_v_i    (commit_v_i),
        .trap_v_i      (trap_v_i),
        .commit_pc_i   (commit_pc_i),
        .commit_instr_i(commit_instr_i),
        .instr_cap_i   (instr_cap_i),
        .drained_i     (drained_i),
        .instr_cnt_o   (instr_cnt_o),
        .state_o       (state_o),
        .finish_o      (finish_o),
        .hang_o        (hang_o),
        .loop_o        (loop_o),
        .cap_o         (cap_o)
    );

    typedef struct {
        logic             en, freeze, commit_v, trap_v, drained;
        logic [va_lp-1:0] pc;
        logic [31:0]      instr;
        logic [31:0]      exp_cnt;
        logic [1:0]       exp_state;
        logic             exp_finish, exp_cap, exp_loop, exp_hang;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic frz, input logic cv, input logic tv,
                                input logic [va_lp-1:0] pc, input logic [31:0] cnt,
                                input logic [1:0] st, input logic fin, input logic cap);
        vec_t v;
        v.en = en; v.freeze = frz; v.commit_v = cv; v.trap_v = tv; v.drained = 1'b1;
        v.pc = pc; v.instr = nop; v.exp_cnt = cnt; v.exp_state = st;
        v.exp_finish = fin; v.exp_cap = cap; v.exp_loop = 1'b0; v.exp_hang = 1'b0;
        return v;
    endfunction

    // Sample #1 after the active edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        freeze_i = 1'b0; commit_v_i = 1'b0; trap_v_i = 1'b0;
        commit_pc_i = '0; commit_instr_i = nop;
    endtask

    task automatic do_reset();
        idle_inputs();
        en_i = 1'b0;
        reset_i = 1'b1;
        #2;
        reset_i = 1'b0;
        #1;
    endtask

    task automatic commit(input logic [va_lp-1:0] pc, input logic [31:0] ins);
        commit_v_i = 1'b1; commit_pc_i = pc; commit_instr_i = ins;
        tick();
        commit_v_i = 1'b0;
    endtask

    task automatic start_run();
        en_i = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset_i = 1'b1; en_i = 1'b0; drained_i = 1'b1; instr_cap_i = 32'd10;
        idle_inputs();
        #3;
        check("reset_state", {62'd0, state_o}, {62'd0, s_idle});
        check("reset_outs", {instr_cnt_o, 28'd0, finish_o, hang_o, loop_o, cap_o}, 64'd0);
        reset_i = 1'b0;
        tick();
        check("idle_no_en", {62'd0, state_o}, {62'd0, s_idle});

        // Cap = 10 with an enable drop, a trap-only cycle and a frozen commit along the way.
        vecs.push_back(mk(1, 0, 0, 0, 39'h1000, 0,  s_run,   0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 39'h1004, 1,  s_run,   0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 39'h1008, 2,  s_run,   0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 39'h100c, 3,  s_run,   0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 39'h1010, 3,  s_idle,  0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 39'h1010, 3,  s_run,   0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 39'h1014, 4,  s_run,   0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 39'h1018, 5,  s_run,   0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 39'h101c, 5,  s_run,   0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 39'h1020, 6,  s_run,   0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 39'h1024, 7,  s_run,   0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 39'h1028, 8,  s_run,   0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 39'h102c, 9,  s_run,   0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 39'h1030, 10, s_drain, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 39'h1034, 10, s_done,  1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 39'h1038, 10, s_done,  1, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            en_i = vecs[i].en; freeze_i = vecs[i].freeze; commit_v_i = vecs[i].commit_v;
            trap_v_i = vecs[i].trap_v; commit_pc_i = vecs[i].pc; commit_instr_i = vecs[i].instr;
            drained_i = vecs[i].drained;
            tick();
            check($sformatf("vec%0d_cnt", i),   {32'd0, instr_cnt_o}, {32'd0, vecs[i].exp_cnt});
            check($sformatf("vec%0d_state", i), {62'd0, state_o},     {62'd0, vecs[i].exp_state});
            check($sformatf("vec%0d_flags", i), {60'd0, finish_o, cap_o, loop_o, hang_o},
                  {60'd0, vecs[i].exp_finish, vecs[i].exp_cap, vecs[i].exp_loop, vecs[i].exp_hang});
        end

        // Self-loop: 8 self-jumps at one PC, drain never reports empty.
        do_reset();
        instr_cap_i = 32'd0; drained_i = 1'b0;
        start_run();
        for (int i = 0; i < 7; i++) commit(39'h8000_0040, jal_self);
        check("loop_7th_state", {62'd0, state_o}, {62'd0, s_run});
        check("loop_7th_flag", {63'd0, loop_o}, 64'd0);
        commit(39'h8000_0040, jal_self);
        check("loop_8th_state", {62'd0, state_o}, {62'd0, s_drain});
        check("loop_8th_flag", {62'd0, loop_o, finish_o}, {62'd0, 2'b10});
        n = 1;
        while (state_o == s_drain && n < 200) begin
            tick();
            if (state_o == s_drain) n++;
        end
        check("loop_drain_cycles", 64'(n), 64'd64);
        check("loop_done", {61'd0, state_o, finish_o}, {61'd0, s_done, 1'b1});
        check("loop_sticky", {60'd0, loop_o, cap_o, hang_o, 1'b0}, {60'd0, 4'b1000});
        check("loop_cnt", {32'd0, instr_cnt_o}, 64'd8);

        // Variant: switching PC restarts the run length at 1.
        do_reset();
        drained_i = 1'b1;
        start_run();
        for (int i = 0; i < 7; i++) commit(39'h8000_0040, jal_self);
        commit(39'h8000_0080, jal_self);
        check("loopvar_no_flag", {61'd0, state_o, loop_o}, {61'd0, s_run, 1'b0});
        for (int i = 0; i < 6; i++) commit(39'h8000_0080, jal_self);
        check("loopvar_7_at_b", {61'd0, state_o, loop_o}, {61'd0, s_run, 1'b0});
        commit(39'h8000_0080, jal_self);
        check("loopvar_8_at_b", {61'd0, state_o, loop_o}, {61'd0, s_drain, 1'b1});
        tick();
        check("loopvar_finish", {63'd0, finish_o}, 64'd1);

        // Hang: one commit then silence; fires exactly 16 cycles later, no DRAIN.
        do_reset();
        start_run();
        commit(39'h2000, nop);
        n = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (state_o == s_drain) n++;
            if (k == 15) check("hang_k15", {60'd0, state_o, hang_o, finish_o}, {60'd0, s_run, 2'b00});
        end
        check("hang_k16", {60'd0, state_o, hang_o, finish_o}, {60'd0, s_done, 2'b11});
        check("hang_no_drain", 64'(n), 64'd0);

        // Freeze for 1000 cycles, then a trap every 10 cycles: no hang, count unchanged.
        do_reset();
        start_run();
        for (int i = 0; i < 3; i++) commit(39'h3000 + 39'(4 * i), nop);
        freeze_i = 1'b1;
        for (int i = 0; i < 1000; i++) tick();
        freeze_i = 1'b0;
        check("freeze_no_hang", {61'd0, state_o, hang_o}, {61'd0, s_run, 1'b0});
        for (int i = 0; i < 100; i++) begin
            trap_v_i = (i % 10 == 0);
            tick();
        end
        trap_v_i = 1'b0;
        check("trap_no_hang", {61'd0, state_o, hang_o}, {61'd0, s_run, 1'b0});
        check("trap_cnt", {32'd0, instr_cnt_o}, 64'd3);

        // Async reset while draining.
        do_reset();
        instr_cap_i = 32'd2; drained_i = 1'b0;
        start_run();
        commit(39'h4000, nop);
        commit(39'h4004, nop);
        tick();
        check("rst_in_drain", {62'd0, state_o}, {62'd0, s_drain});
        #1;
        reset_i = 1'b1;
        #1;
        check("rst_async_outs", {instr_cnt_o, 28'd0, finish_o, hang_o, loop_o, cap_o}, 64'd0);
        check("rst_async_state", {62'd0, state_o}, {62'd0, s_idle});
        #1;
        reset_i = 1'b0;

        // Saturation of the retired-instruction counter.
        do_reset();
        instr_cap_i = 32'd0; drained_i = 1'b1;
        start_run();
        force dut.instr_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.instr_cnt_q;
        for (int i = 0; i < 3; i++) begin
            commit(39'h5000 + 39'(4 * i), nop);
            check($sformatf("sat_%0d", i), {32'd0, instr_cnt_o}, 64'hFFFF_FFFF);
        end
        check("sat_state", {62'd0, state_o}, {62'd0, s_run});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bp_nonsynth_commit_watchdog.md
# bp_nonsynth_commit_watchdog

Nonsynthesizable run-control monitor that sits directly downstream of the core's commit path, beside the cosimulation checker. It counts retired instructions, detects hangs (no commit activity for too long) and self-loop termination (`jal x0, 0` retiring repeatedly at the same PC), and enforces an instruction cap. After any of these end conditions, it drains outstanding commit records before raising a sticky `finish_o` to the testbench.

## Interface
Parameters:
- `vaddr_width_p`, 39, width of the committed PC
- `stall_timeout_p`, 16384, number of idle RUN cycles before a hang is declared; must be ≥ 2
- `loop_threshold_p`, 8, number of consecutive self-jump commits at the same PC that ends the run; must be ≥ 1
- `drain_cycles_p`, 64, maximum number of cycles spent in DRAIN

Ports:
- `clk_i`  in  1  clock
- `reset_i`  in  1  reset; asynchronous, active-high
- `freeze_i`  in  1  core frozen; pauses stall detection
- `en_i`  in  1  monitor enable
- `commit_v_i`  in  1  one non-debug instruction retired this cycle
- `trap_v_i`  in  1  exception or interrupt taken this cycle
- `commit_pc_i`  in  `vaddr_width_p`  PC of the retiring instruction
- `commit_instr_i`  in  32  encoding of the retiring instruction
- `instr_cap_i`  in  32  instruction cap; 0 means no cap
- `drained_i`  in  1  downstream commit/writeback FIFOs are empty
- `instr_cnt_o`  out  32  retired-instruction count, saturating
- `state_o`  out  2  current state: IDLE=0, RUN=1, DRAIN=2, DONE=3
- `finish_o`  out  1  run complete, sticky
- `hang_o`  out  1  ended by stall timeout, sticky
- `loop_o`  out  1  ended by self-loop detection, sticky
- `cap_o`  out  1  ended by instruction cap, sticky

## Operation
- **Reset values:** all outputs are 0 and the state is IDLE. `instr_cnt`, `stall_cnt`, `loop_cnt`, `drain_cnt` and `last_pc` are all 0.
- **IDLE:** go to RUN when `en_i & ~freeze_i`. No counter moves in IDLE.
- **RUN, instruction count:** `commit_v_i` increments `instr_cnt`, saturating at 32'hFFFF_FFFF.
- **RUN, stall counter:**
  - Cleared to 0 on `commit_v_i | trap_v_i`.
  - Held while `freeze_i` is high.
  - Otherwise incremented by 1.
- **RUN, hang:** when `stall_cnt == stall_timeout_p-1` and the counter would increment this cycle, set `hang_o` and go directly to DONE, skipping DRAIN.
- **RUN, self-loop tracking:** on `commit_v_i`:
  - If `commit_instr_i == 32'h0000006f` and `commit_pc_i == last_pc`, increment `loop_cnt`.
  - Else if `commit_instr_i == 32'h0000006f`, set `loop_cnt` to 1.
  - Otherwise set `loop_cnt` to 0.
  - In all three cases, `last_pc` takes `commit_pc_i`.
- **RUN, self-loop end:** when the updated `loop_cnt` equals `loop_threshold_p`, set `loop_o` and go to DRAIN.
- **RUN, cap end:** when `instr_cap_i != 0` and the updated `instr_cnt == instr_cap_i`, set `cap_o` and go to DRAIN.
- **RUN, simultaneous cap and loop:** both flags are set and the state goes to DRAIN. A commit clears the stall counter, so hang can never coincide with cap or loop.
- **RUN, mid-run changes:** `en_i` falling in RUN returns to IDLE with all counters held, not cleared. `trap_v_i` never changes `instr_cnt` or `loop_cnt`.
- **DRAIN:**
  - `drain_cnt` increments every cycle.
  - Go to DONE when `drained_i`, or when `drain_cnt == drain_cycles_p-1`.
  - Commits during DRAIN still increment `instr_cnt`. End-condition checks are disabled.
- **DONE:** terminal; `finish_o` = 1. Leave only via `reset_i`.
- **Async reset mid-operation:** asserting `reset_i` in any state forces the reset values immediately, without waiting for a clock edge.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- `instr_cnt_o` reflects a commit on the cycle after the commit.
- Hang: `finish_o` and `hang_o` rise on the edge following the timeout cycle, i.e. `stall_timeout_p` idle cycles after the last activity.
- Cap/loop:
  - `cap_o`/`loop_o` rise one cycle after the triggering commit, when `state_o` becomes DRAIN.
  - If `drained_i` is already 1, `finish_o` rises one cycle after that.
- Worst-case DRAIN residency is `drain_cycles_p` cycles.
- `finish_o` and the end-condition flags never deassert without reset.

## Test plan
- **Cap:** `instr_cap_i`=10, one commit per cycle at distinct PCs, `drained_i`=1.
  - Required: `cap_o` rises the cycle after the 10th commit.
  - Required: `finish_o` rises one cycle later.
  - Required: `instr_cnt_o`=10.
- **Self-loop:** 8 commits of 32'h0000006f at PC 0x80000040, then `drained_i` held 0.
  - Required: `loop_o` rises after the 8th commit.
  - Required: DRAIN lasts 64 cycles, then `finish_o`=1.
  - Variant: a self-jump at a new PC restarts the count at 1, so no `loop_o` after the 8th commit.
- **Hang:** `stall_timeout_p`=16, one commit, then idle.
  - Required: `hang_o` and `finish_o` assert together exactly 16 cycles after the commit; `state_o` steps RUN→DONE.
- **Freeze and trap:** `freeze_i` high for 1000 cycles mid-run, then a trap every 10 cycles.
  - Required: no hang fires.
  - Required: `instr_cnt_o` is unchanged by the traps.
- **Mid-operation reset:** assert `reset_i` asynchronously while in DRAIN.
  - Required: all outputs go to 0 before the next clock edge.
  - Required: the state is IDLE.
- **Saturation:** force `instr_cnt`=32'hFFFF_FFFE with cap=0, then 3 commits.
  - Required: `instr_cnt_o` holds at 32'hFFFF_FFFF.
